// File: rtl/pixel_scheduler_if.sv
// pixel_scheduler_if
//   Pixel handshake between the raster scheduler and the ray generation
//   pipeline.
//   pixel_valid : scheduler holds a pixel to issue
//   pixel_ready : ray pipeline can accept the pixel (inverse of its stall)
//   pixel_x     : current pixel column
//   pixel_y     : current pixel row
//   Modports: master (scheduler side), slave (pipeline side).
interface pixel_scheduler_if #(
    parameter int unsigned COORD_W = 10
);
    logic               pixel_valid;
    logic               pixel_ready;
    logic [COORD_W-1:0] pixel_x;
    logic [COORD_W-1:0] pixel_y;

    modport master (
        output pixel_valid,
        output pixel_x,
        output pixel_y,
        input  pixel_ready
    );

    modport slave (
        input  pixel_valid,
        input  pixel_x,
        input  pixel_y,
        output pixel_ready
    );
endinterface

// File: rtl/pixel_scheduler.sv
// pixel_scheduler
//   Raster-scan sequencer feeding (x, y) pixel coordinates into the ray
//   generation pipeline, one frame per start pulse. In-flight rays are
//   limited by a credit counter replenished by downstream retire pulses.
//
// Ports:
//   clk, rst      : clock (rising edge), asynchronous active-high reset
//   start         : frame start request, honoured only when idle
//   frame_w/h     : frame dimensions, sampled on an accepted start
//   pix           : pixel handshake (pixel_valid/ready, pixel_x/y), master side
//   ray_retire    : one pulse per ray completed downstream
//   inflight      : number of issued, not yet retired rays
//   busy          : high whenever a frame is in progress (not idle)
//   frame_done    : one-cycle pulse when the frame has fully retired
//   retire_err    : sticky, a retire arrived while inflight was zero
//
// Optional feature (macro PIXEL_SCHED_PERF_EN):
//   frame_cycles  : cycles from scan entry through done, saturating
//   stall_cycles  : scan cycles with pixel_valid && !pixel_ready, saturating
module pixel_scheduler #(
    parameter int unsigned COORD_W      = 10,
    parameter int unsigned MAX_INFLIGHT = 16,
    parameter int unsigned CNT_W        = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [COORD_W-1:0]  frame_w,
    input  logic [COORD_W-1:0]  frame_h,
    pixel_scheduler_if.master   pix,
    input  logic                ray_retire,
    output logic [CNT_W-1:0]    inflight,
    output logic                busy,
    output logic                frame_done,
    output logic                retire_err
`ifdef PIXEL_SCHED_PERF_EN
    ,
    output logic [31:0]         frame_cycles,
    output logic [31:0]         stall_cycles
`endif
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_INFLIGHT);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DRAIN,
        DONE
    } state_t;

    state_t             state, state_n;
    logic [COORD_W-1:0] w_q, h_q, x_q, y_q;
    logic [COORD_W-1:0] w_n, h_n, x_n, y_n;
    logic [CNT_W-1:0]   inflight_n;
    logic               valid_n;
    logic               err_n;
    logic               fire;
    logic               start_ok;

    assign fire     = pix.pixel_valid && pix.pixel_ready;
    assign start_ok = (state == IDLE) && start;

    // Fire and retire together cancel; a retire with nothing in flight
    // leaves the counter at zero and is flagged instead.
    always_comb begin
        inflight_n = inflight;
        if (fire && !ray_retire)
            inflight_n = inflight + CNT_W'(1);
        else if (!fire && ray_retire && inflight != '0)
            inflight_n = inflight - CNT_W'(1);
        err_n = retire_err || (ray_retire && inflight == '0);
    end

    always_comb begin
        state_n = state;
        w_n     = w_q;
        h_n     = h_q;
        x_n     = x_q;
        y_n     = y_q;
        case (state)
            IDLE: begin
                if (start) begin
                    if (frame_w != '0 && frame_h != '0) begin
                        state_n = SCAN;
                        w_n     = frame_w;
                        h_n     = frame_h;
                        x_n     = '0;
                        y_n     = '0;
                    end else begin
                        state_n = DONE;
                    end
                end
            end
            SCAN: begin
                if (fire) begin
                    if (x_q == w_q - COORD_W'(1)) begin
                        // Last pixel keeps its coordinates while draining.
                        if (y_q == h_q - COORD_W'(1)) begin
                            state_n = DRAIN;
                        end else begin
                            x_n = '0;
                            y_n = y_q + COORD_W'(1);
                        end
                    end else begin
                        x_n = x_q + COORD_W'(1);
                    end
                end
            end
            DRAIN: begin
                if (inflight_n == '0)
                    state_n = DONE;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        // Registered valid: derived from next state and next credit count,
        // never from pixel_ready combinationally.
        valid_n = (state_n == SCAN) && (inflight_n < MAX_CNT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_q             <= '0;
            h_q             <= '0;
            x_q             <= '0;
            y_q             <= '0;
            inflight        <= '0;
            retire_err      <= 1'b0;
            pix.pixel_valid <= 1'b0;
        end else begin
            w_q             <= w_n;
            h_q             <= h_n;
            x_q             <= x_n;
            y_q             <= y_n;
            inflight        <= inflight_n;
            retire_err      <= err_n;
            pix.pixel_valid <= valid_n;
        end
    end

    assign pix.pixel_x = x_q;
    assign pix.pixel_y = y_q;
    assign busy        = (state != IDLE);
    assign frame_done  = (state == DONE);

`ifdef PIXEL_SCHED_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cycles <= '0;
            stall_cycles <= '0;
        end else if (start_ok) begin
            frame_cycles <= '0;
            stall_cycles <= '0;
        end else begin
            if (state != IDLE && frame_cycles != '1)
                frame_cycles <= frame_cycles + 32'd1;
            if (state == SCAN && pix.pixel_valid && !pix.pixel_ready &&
                stall_cycles != '1)
                stall_cycles <= stall_cycles + 32'd1;
        end
    end
`else
    logic unused_start_ok;
    assign unused_start_ok = start_ok;
`endif

endmodule

// File: tb/tb_pixel_scheduler.sv
// tb_pixel_scheduler
//   Randomized self-checking bench for pixel_scheduler. A behavioural model
//   tracks the frame as a linear pixel index k (x = k % w, y = k / w) and the
//   credit count as issued minus retired; every cycle the DUT outputs are
//   compared against it, plus named checks for the scenarios of interest.
module tb_pixel_scheduler;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned MAXI    = 16;
    localparam int unsigned CNT_W   = 8;

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic [COORD_W-1:0] frame_w, frame_h;
    logic               ray_retire;
    logic [CNT_W-1:0]   inflight;
    logic               busy, frame_done, retire_err;
`ifdef PIXEL_SCHED_PERF_EN
    logic [31:0]        frame_cycles, stall_cycles;
`endif

    pixel_scheduler_if #(.COORD_W(COORD_W)) pix ();

    pixel_scheduler #(
        .COORD_W      (COORD_W),
        .MAX_INFLIGHT (MAXI),
        .CNT_W        (CNT_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .frame_w      (frame_w),
        .frame_h      (frame_h),
        .pix          (pix),
        .ray_retire   (ray_retire),
        .inflight     (inflight),
        .busy         (busy),
        .frame_done   (frame_done),
        .retire_err   (retire_err)
`ifdef PIXEL_SCHED_PERF_EN
        ,
        .frame_cycles (frame_cycles),
        .stall_cycles (stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_mis = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum int {M_IDLE, M_SCAN, M_DRAIN, M_DONE} m_phase_t;
    m_phase_t    m_phase;
    int unsigned m_k, m_n, m_w, m_x, m_y, m_infl;
    bit          m_valid, m_err;
    longint unsigned m_fc, m_sc;

    int unsigned cyc;
    int unsigned due[$];          // edge numbers at which a retire is due
    int unsigned ready_mode;      // 0: always 1, 1: random, 2: manual
    int unsigned ret_mode;        // 0: none, 1: 3 cycles after fire, 2: random, 3: manual
    int unsigned dut_fires, done_cnt, max_infl;
    logic [2*COORD_W-1:0] last_xy;

    task automatic model_reset();
        m_phase = M_IDLE;
        m_k = 0; m_n = 0; m_w = 1; m_x = 0; m_y = 0; m_infl = 0;
        m_valid = 0; m_err = 0; m_fc = 0; m_sc = 0;
        due.delete();
    endtask

    task automatic model_edge();
        bit fire;
        int unsigned old;
        cyc++;
        fire = m_valid && pix.pixel_ready;
        old  = m_infl;
        if (fire && !ray_retire)
            m_infl++;
        else if (!fire && ray_retire && m_infl > 0)
            m_infl--;
        if (ray_retire && old == 0)
            m_err = 1;
        if (m_phase != M_IDLE && m_fc != 64'hFFFF_FFFF) m_fc++;
        if (m_phase == M_SCAN && m_valid && !pix.pixel_ready && m_sc != 64'hFFFF_FFFF) m_sc++;
        case (m_phase)
            M_IDLE: if (start) begin
                m_fc = 0; m_sc = 0;
                if (frame_w != 0 && frame_h != 0) begin
                    m_phase = M_SCAN;
                    m_k = 0; m_w = frame_w; m_n = frame_w * frame_h;
                    m_x = 0; m_y = 0;
                end else begin
                    m_phase = M_DONE;
                end
            end
            M_SCAN: if (fire) begin
                m_k++;
                if (ret_mode == 1) due.push_back(cyc + 3);
                if (m_k == m_n) m_phase = M_DRAIN;
                else begin
                    m_x = m_k % m_w;
                    m_y = m_k / m_w;
                end
            end
            M_DRAIN: if (m_infl == 0) m_phase = M_DONE;
            M_DONE:  m_phase = M_IDLE;
            default: m_phase = M_IDLE;
        endcase
        m_valid = (m_phase == M_SCAN) && (m_infl < MAXI);
    endtask

    function automatic logic [31:0] dut_vec();
        return {pix.pixel_valid, pix.pixel_x, pix.pixel_y, inflight, busy, frame_done, retire_err};
    endfunction

    function automatic logic [31:0] model_vec();
        return {m_valid, COORD_W'(m_x), COORD_W'(m_y), CNT_W'(m_infl),
                m_phase != M_IDLE, m_phase == M_DONE, m_err};
    endfunction

    task automatic drive_next();
        case (ready_mode)
            0: pix.pixel_ready = 1'b1;
            1: pix.pixel_ready = ($urandom_range(0, 3) != 0);
            default: ;
        endcase
        case (ret_mode)
            0: ray_retire = 1'b0;
            1: if (due.size() > 0 && due[0] == cyc + 1) begin
                   ray_retire = 1'b1;
                   due.delete(0);
               end else begin
                   ray_retire = 1'b0;
               end
            2: ray_retire = (m_infl > 0) && ($urandom_range(0, 2) == 0);
            default: ;
        endcase
    endtask

    task automatic step();
        if (pix.pixel_valid && pix.pixel_ready) begin
            dut_fires++;
            last_xy = {pix.pixel_x, pix.pixel_y};
        end
        @(posedge clk);
        model_edge();
        #1;
        check("cycle", 64'(dut_vec()), 64'(model_vec()));
        if (frame_done) done_cnt++;
        if (inflight > max_infl) max_infl = inflight;
        drive_next();
    endtask

    task automatic start_frame(input int unsigned w, input int unsigned h);
        frame_w = COORD_W'(w);
        frame_h = COORD_W'(h);
        start = 1'b1;
        dut_fires = 0; done_cnt = 0; max_infl = 0;
        step();
        start = 1'b0;
        frame_w = COORD_W'($urandom);
        frame_h = COORD_W'($urandom);
    endtask

    task automatic run_frame(input int unsigned budget);
        int unsigned n = 0;
        while (m_phase != M_IDLE && n < budget) begin
            step();
            n++;
        end
        if (m_phase != M_IDLE) check("timeout", 64'd1, 64'd0);
    endtask

    initial begin
        int unsigned pre;
        rst = 1'b1; start = 1'b0; frame_w = '0; frame_h = '0;
        ray_retire = 1'b0; pix.pixel_ready = 1'b0;
        cyc = 0; ready_mode = 0; ret_mode = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset", 64'(dut_vec()), 64'd0);
`ifdef PIXEL_SCHED_PERF_EN
        check("reset_perf", {frame_cycles, stall_cycles}, 64'd0);
`endif
        rst = 1'b0;
        drive_next();

        // 4x3 frame, retire 3 cycles after each fire
        ready_mode = 0; ret_mode = 1;
        start_frame(4, 3);
        run_frame(200);
        check("t1_fires", 64'(dut_fires), 64'd12);
        check("t1_last", 64'(last_xy), {44'd0, 10'd3, 10'd2});
        check("t1_done", 64'(done_cnt), 64'd1);

        // credit limit: 8x8, no retires
        ready_mode = 0; ret_mode = 0;
        start_frame(8, 8);
        repeat (20) step();
        check("credit_stop", 64'(dut_fires), 64'd16);
        check("credit_infl", 64'(inflight), 64'd16);
        check("credit_valid", 64'(pix.pixel_valid), 64'd0);
        ret_mode = 3;
        for (int unsigned i = 0; i < 3; i++) begin
            ray_retire = 1'b1;
            step();
            ray_retire = 1'b0;
            repeat (3) step();
            check("credit_refill", 64'(dut_fires), 64'(17 + i));
        end
        check("credit_cap", 64'(max_infl), 64'd16);
        ret_mode = 2;
        run_frame(2000);
        check("credit_fires", 64'(dut_fires), 64'd64);

        // 128x104 frame, 5-cycle stall at (100,100), start ignored while busy
        ready_mode = 2; ret_mode = 1; pix.pixel_ready = 1'b1;
        start_frame(128, 104);
        begin
            int unsigned n = 0;
            while (!(m_valid && m_x == 100 && m_y == 100) && n < 20000) begin
                step();
                n++;
            end
        end
        pix.pixel_ready = 1'b0;
        for (int unsigned i = 0; i < 5; i++) begin
            start = (i == 2);
            frame_w = 10'd3; frame_h = 10'd3;
            step();
            check("stall_hold", {44'd0, pix.pixel_x, pix.pixel_y}, {44'd0, 10'd100, 10'd100});
        end
        start = 1'b0;
        pix.pixel_ready = 1'b1;
        run_frame(20000);
        check("t3_fires", 64'(dut_fires), 64'd13312);
        check("t3_last", 64'(last_xy), {44'd0, 10'd127, 10'd103});
`ifdef PIXEL_SCHED_PERF_EN
        check("stall_cycles", 64'(stall_cycles), 64'd5);
        check("frame_cycles", 64'(frame_cycles), m_fc);
`endif

        // zero-width frame
        ready_mode = 0; ret_mode = 0;
        start_frame(0, 5);
        check("zero_busy", {62'd0, busy, frame_done}, 64'd3);
        run_frame(10);
        check("zero_fires", 64'(dut_fires), 64'd0);
        check("zero_idle", 64'(busy), 64'd0);

        // fire and retire in the same cycle, then random traffic
        ready_mode = 0; ret_mode = 3; ray_retire = 1'b0;
        start_frame(6, 5);
        repeat (3) step();
        pre = m_infl;
        ray_retire = 1'b1;
        step();
        ray_retire = 1'b0;
        check("fire_retire", 64'(inflight), 64'(pre));
        ready_mode = 1; ret_mode = 2;
        run_frame(2000);
        check("t5_fires", 64'(dut_fires), 64'd30);

        // retire with nothing in flight
        ready_mode = 0; ret_mode = 3;
        ray_retire = 1'b1;
        step();
        ray_retire = 1'b0;
        check("retire_err", 64'(retire_err), 64'd1);
        check("retire_err_cnt", 64'(inflight), 64'd0);
        repeat (5) step();
        check("err_sticky", 64'(retire_err), 64'd1);

        // asynchronous reset mid-scan at (2,1)
        ret_mode = 0;
        start_frame(4, 3);
        begin
            int unsigned n = 0;
            while (!(m_x == 2 && m_y == 1) && n < 50) begin
                step();
                n++;
            end
        end
        check("pre_rst_xy", {44'd0, pix.pixel_x, pix.pixel_y}, {44'd0, 10'd2, 10'd1});
        #2 rst = 1'b1;
        #1;
        check("async_rst", 64'(dut_vec()), 64'd0);
`ifdef PIXEL_SCHED_PERF_EN
        check("async_rst_perf", {frame_cycles, stall_cycles}, 64'd0);
`endif
        model_reset();
        @(posedge clk);
        #1 rst = 1'b0;
        check("rst_hold", 64'(dut_vec()), 64'd0);
        ret_mode = 1;
        drive_next();
        start_frame(4, 3);
        check("restart_xy", {43'd0, pix.pixel_valid, pix.pixel_x, pix.pixel_y}, {43'd0, 1'b1, 10'd0, 10'd0});
        run_frame(200);
        check("restart_fires", 64'(dut_fires), 64'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/pixel_scheduler.md
Name: pixel_scheduler

Overview:
- Raster-scan sequencer that feeds pixel coordinates into the ray generation pipeline (generate_ray) for one frame at a time.
- On a start pulse it walks x then y across a configurable frame, presenting one (pixel_x, pixel_y) per accepted handshake.
- It limits in-flight rays with a credit counter that is replenished by retire pulses from downstream.
- It reports busy and pulses frame_done once every issued ray has retired.

Parameters:
- COORD_W, 10, width of the pixel coordinates and frame dimensions.
- MAX_INFLIGHT, 16, maximum number of issued but not yet retired rays (range 1..255).
- CNT_W, 8, width of the in-flight counter; must satisfy 2^CNT_W > MAX_INFLIGHT.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle frame start request; honoured only in IDLE.
- frame_w  in  COORD_W  frame width in pixels; sampled on an accepted start.
- frame_h  in  COORD_W  frame height in pixels; sampled on an accepted start.
- pixel_valid  out  1  pixel_x/pixel_y hold a pixel to issue.
- pixel_ready  in  1  ray pipeline can accept a pixel (the inverse of its stall).
- pixel_x  out  COORD_W  current pixel column.
- pixel_y  out  COORD_W  current pixel row.
- ray_retire  in  1  one ray completed downstream, one pulse per ray.
- inflight  out  CNT_W  number of outstanding rays.
- busy  out  1  high whenever state != IDLE.
- frame_done  out  1  one-cycle pulse at frame completion.
- retire_err  out  1  sticky flag: a retire arrived while inflight == 0.

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - State goes to IDLE.
  - Every output goes to 0: pixel_valid, pixel_x, pixel_y, inflight, busy, frame_done, retire_err.
  - The latched frame_w and frame_h are cleared.
- Fire is defined as pixel_valid && pixel_ready.
- State IDLE:
  - start=1 with frame_w != 0 and frame_h != 0: latch both dimensions, go to SCAN. pixel_valid rises on the next edge with x=0, y=0.
  - start=1 with frame_w == 0 or frame_h == 0: go straight to DONE. No pixel is issued.
- State SCAN:
  - pixel_valid = (inflight < MAX_INFLIGHT); this is registered, and must not depend combinationally on pixel_ready.
  - While pixel_valid is high and pixel_ready is low, pixel_x and pixel_y hold stable.
  - On fire, x increments. When x == w-1, x wraps to 0 and y increments.
  - A fire on (w-1, h-1) moves the state to DRAIN. pixel_valid drops on the next edge; x and y hold their last value.
- State DRAIN:
  - pixel_valid stays 0.
  - When the next value of inflight will be 0, go to DONE. A retire on the same cycle counts toward this.
- State DONE:
  - frame_done = 1 for exactly one cycle, then go to IDLE.
  - busy remains high during DONE.
- Latency: start to first pixel_valid is 1 cycle.
- Throughput: one pixel per cycle while pixel_ready=1 and credits are available.
- In-flight counter:
  - Fire alone adds 1; ray_retire alone subtracts 1.
  - Fire and retire in the same cycle leave the count unchanged.
  - A retire with inflight == 0 leaves the count at 0 and sets retire_err, which is cleared only by reset.
  - Retires are counted in every state, including IDLE.
- start while busy is ignored.
- Changes to frame_w/frame_h after start do not affect the frame in progress.

Optional Feature:
- Macro: PIXEL_SCHED_PERF_EN.
- When defined, two extra outputs are added:
  - frame_cycles[31:0]: counts cycles from SCAN entry through DONE inclusive.
  - stall_cycles[31:0]: counts SCAN cycles with pixel_valid && !pixel_ready.
  - Both clear on an accepted start and on reset, hold after DONE, and saturate at all ones.
- When undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Reset, start, frame_w=4, frame_h=3, pixel_ready=1, ray_retire pulsed 3 cycles after each fire:
  - 12 fires in raster order (0,0),(1,0)...(3,2), no repeated or skipped coordinate.
  - frame_done pulses once after the last retire; busy falls the following cycle.
- MAX_INFLIGHT=16, frame 8x8, no retires:
  - pixel_valid drops after exactly 16 fires with inflight=16.
  - Single retire pulses re-enable one fire each; inflight never exceeds 16.
- frame 800x600 with pixel_ready deasserted for 5 cycles at pixel (100,100):
  - pixel_x=100, pixel_y=100 held through the stall.
  - The total fire count is 480000 and coordinate (799,599) is last.
- start with frame_w=0, frame_h=5:
  - No pixel_valid.
  - busy high 1 cycle, frame_done pulse, return to IDLE.
- Fire and retire in the same cycle: inflight unchanged. Retire with inflight=0: retire_err=1 and sticky.
- Assert rst mid-SCAN at pixel (2,1):
  - All outputs go to 0 immediately, without waiting for a clock edge.
  - A subsequent start restarts from (0,0).
  - With PIXEL_SCHED_PERF_EN, frame_cycles and stall_cycles return to 0.
